// File: rtl/mic_sample_fifo_if.sv
// mic_sample_fifo_if: consumer read port of the mic sample FIFO.
// master = consumer, slave = FIFO.
interface mic_sample_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  rd_en;
  logic [15:0]           rd_data;
  logic                  rd_valid;
  logic                  empty;
  logic                  full;
  logic [DEPTH_LOG2:0]   level;

  modport master (
    output rd_en,
    input  rd_data,
    input  rd_valid,
    input  empty,
    input  full,
    input  level
  );

  modport slave (
    input  rd_en,
    output rd_data,
    output rd_valid,
    output empty,
    output full,
    output level
  );
endinterface

// File: rtl/mic_sample_fifo.sv
// mic_sample_fifo: ws-edge capture, 18->16 round/saturate, circular FIFO.
// Optional peak magnitude tracker enabled by MIC_PEAK_EN.
module mic_sample_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [17:0] sdata_in,
  input  logic        ws_in,
  input  logic        ovf_clr,
  input  logic        peak_clr,
  output logic        overflow,
  output logic [15:0] peak,
  mic_sample_fifo_if.slave rd
);

  localparam logic [DEPTH_LOG2:0] DEPTH =
    {1'b1, {DEPTH_LOG2{1'b0}}};

  logic                  ws_s1, ws_s2, ws_s3;
  logic                  ws_edge;
  logic [15:0]           conv;
  logic [15:0]           hi;
  logic [15:0]           cap;
  logic                  wr_pend;
  logic [15:0]           mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   level;
  logic [15:0]           rd_data;
  logic                  rd_valid;
  logic                  is_empty, is_full;
  logic                  rd_acc, wr_acc, wr_drop;

  assign ws_edge = ws_s2 != ws_s3;
  assign hi      = sdata_in[17:2];

  always_comb begin
    conv = hi + {15'd0, sdata_in[1]};
    if (hi == 16'h7FFF && sdata_in[1])
      conv = 16'h7FFF;
  end

  assign is_empty = level == '0;
  assign is_full  = level == DEPTH;
  assign rd_acc   = rd.rd_en && !is_empty;
  assign wr_acc   = wr_pend && (!is_full || rd_acc);
  assign wr_drop  = wr_pend && is_full && !rd_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_s1   <= 1'b0;
      ws_s2   <= 1'b0;
      ws_s3   <= 1'b0;
      cap     <= '0;
      wr_pend <= 1'b0;
    end else begin
      ws_s1   <= ws_in;
      ws_s2   <= ws_s1;
      ws_s3   <= ws_s2;
      wr_pend <= ws_edge && enable;
      if (ws_edge && enable)
        cap <= conv;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr] <= cap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (wr_acc)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (wr_drop)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

`ifdef MIC_PEAK_EN
  logic [15:0] mag;
  logic [15:0] peak_q;

  always_comb begin
    mag = cap;
    if (cap == 16'h8000)
      mag = 16'h7FFF;
    else if (cap[15])
      mag = ~cap + 16'd1;
  end

  // a clear on a write edge restarts the peak at the new sample
  always_ff @(posedge clk) begin
    if (reset)
      peak_q <= '0;
    else if (wr_acc && (peak_clr || mag > peak_q))
      peak_q <= mag;
    else if (peak_clr)
      peak_q <= '0;
  end

  assign peak = peak_q;
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
  assign peak = 16'h0000;
`endif

  assign rd.rd_data  = rd_data;
  assign rd.rd_valid = rd_valid;
  assign rd.empty    = is_empty;
  assign rd.full     = is_full;
  assign rd.level    = level;

endmodule

// File: tb/tb_mic_sample_fifo.sv
// tb_mic_sample_fifo: directed stimulus with a read-data scoreboard.
// Build with +define+MIC_PEAK_EN to check the peak tracker.
module tb_mic_sample_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [17:0] sdata_in = '0;
  logic        ws = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        peak_clr = 1'b0;
  logic        overflow;
  logic [15:0] peak;

  int n_pass = 0;
  int n_tot  = 0;
  logic [15:0] q[$];

  mic_sample_fifo_if #(.DEPTH_LOG2(4)) rif ();

  mic_sample_fifo #(.DEPTH_LOG2(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .sdata_in (sdata_in),
    .ws_in    (ws),
    .ovf_clr  (ovf_clr),
    .peak_clr (peak_clr),
    .overflow (overflow),
    .peak     (peak),
    .rd       (rif.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tog(input logic [17:0] d);
    sdata_in = d;
    ws = ~ws;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic rd_one(input bit expect_data, input logic [15:0] d);
    if (expect_data) q.push_back(d);
    rif.rd_en = 1'b1;
    @(posedge clk);
    #1 rif.rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && rif.rd_valid) begin
      if (q.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected_rd_valid: got data %h expected none",
                 rif.rd_data);
      end else begin
        chk("rd_data", {16'd0, rif.rd_data}, {16'd0, q.pop_front()});
      end
    end
  end

  initial begin
    rif.rd_en = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(1);
    chk("rst_rd_data", {16'd0, rif.rd_data}, 32'h0);
    chk("rst_rd_valid", {31'd0, rif.rd_valid}, 32'h0);
    chk("rst_empty", {31'd0, rif.empty}, 32'h1);
    chk("rst_full", {31'd0, rif.full}, 32'h0);
    chk("rst_level", {27'd0, rif.level}, 32'h0);
    chk("rst_overflow", {31'd0, overflow}, 32'h0);
    chk("rst_peak", {16'd0, peak}, 32'h0);

    // basic capture then read
    tog(18'h00004);
    chk("one_level", {27'd0, rif.level}, 32'd1);
    chk("one_empty", {31'd0, rif.empty}, 32'd0);
    rd_one(1, 16'h0001);
    idle(1);
    chk("one_empty_after", {31'd0, rif.empty}, 32'd1);

    // rounding and saturation
    tog(18'h1FFFE);
    tog(18'h20000);
    tog(18'h3FFFE);
    tog(18'h00006);
    chk("round_level", {27'd0, rif.level}, 32'd4);
    rd_one(1, 16'h7FFF);
    rd_one(1, 16'h8000);
    rd_one(1, 16'h0000);
    rd_one(1, 16'h0002);
    idle(2);

    // overflow: 17 writes, 16 reads, extra read on empty
    for (int i = 1; i <= 17; i++) tog(18'(i << 2));
    chk("fill_full", {31'd0, rif.full}, 32'd1);
    chk("fill_level", {27'd0, rif.level}, 32'd16);
    chk("fill_ovf", {31'd0, overflow}, 32'd1);
    for (int i = 1; i <= 16; i++) rd_one(1, 16'(i));
    rd_one(0, 16'h0);
    idle(2);
    chk("drain_empty", {31'd0, rif.empty}, 32'd1);
    chk("drain_ovf_sticky", {31'd0, overflow}, 32'd1);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", {31'd0, overflow}, 32'd0);

    // full with a read on the write edge
    for (int i = 1; i <= 16; i++) tog(18'((32'h20 + i) << 2));
    chk("full2", {31'd0, rif.full}, 32'd1);
    sdata_in = 18'h55 << 2;
    ws = ~ws;
    repeat (3) @(posedge clk);
    #1 rif.rd_en = 1'b1;
    q.push_back(16'h0021);
    @(posedge clk);
    #1 rif.rd_en = 1'b0;
    idle(2);
    chk("simul_level", {27'd0, rif.level}, 32'd16);
    chk("simul_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 2; i <= 16; i++) rd_one(1, 16'(32'h20 + i));
    rd_one(1, 16'h0055);
    idle(2);
    chk("simul_empty", {31'd0, rif.empty}, 32'd1);

    // enable low, then reset mid-fill
    tog(18'h00040);
    tog(18'h00044);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) tog(18'h00100);
    chk("dis_level", {27'd0, rif.level}, 32'd2);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) tog(18'h00200);
    chk("mid_level", {27'd0, rif.level}, 32'd5);
    if (ws) begin
      enable = 1'b0;
      tog(18'h00300);
      enable = 1'b1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("mid_rst_level", {27'd0, rif.level}, 32'd0);
    chk("mid_rst_empty", {31'd0, rif.empty}, 32'd1);
    chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    idle(3);
    tog(18'h00008);
    chk("post_rst_level", {27'd0, rif.level}, 32'd1);
    rd_one(1, 16'h0002);
    idle(2);

`ifdef MIC_PEAK_EN
    peak_clr = 1'b1;
    idle(1);
    peak_clr = 1'b0;
    chk("peak_clr0", {16'd0, peak}, 32'h0);
    tog(18'h00400);
    chk("peak_0100", {16'd0, peak}, 32'h0100);
    tog(18'h3F800);
    chk("peak_0200", {16'd0, peak}, 32'h0200);
    tog(18'h20000);
    chk("peak_7fff", {16'd0, peak}, 32'h7FFF);
    peak_clr = 1'b1;
    idle(1);
    peak_clr = 1'b0;
    chk("peak_clr", {16'd0, peak}, 32'h0);
    rd_one(1, 16'h0100);
    rd_one(1, 16'hFE00);
    rd_one(1, 16'h8000);
    idle(2);
`else
    peak_clr = 1'b1;
    tog(18'h1FFFE);
    peak_clr = 1'b0;
    chk("peak_off", {16'd0, peak}, 32'h0);
    rd_one(1, 16'h7FFF);
    idle(2);
`endif

    idle(4);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
